// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// StageSequencer
//
// Steps one instruction through up to NUM_STAGES stage slots. Each executed
// stage runs one or more passes of CYCLES serial ALU cycles. The sequencer can
// fetch an immediate before starting, issue a TX command per stage, and stall
// the ALU on external, RX or TX handshakes.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   inst_valid            : instruction present (fields held until inst_done)
//   inst_done             : single-cycle completion pulse
//   stage_mask            : stages to execute
//   cmd_mask, rx_mask     : stages issuing a TX command / consuming RX data
//   repeat_stage          : stage index that runs repeat_count passes
//   repeat_count          : pass count for repeat_stage (0 removes that stage)
//   skip                  : instruction is a no-op / failed condition
//   need_imm16            : instruction needs a 16-bit immediate
//   imm16_loaded          : immediate load finished
//   load_imm16            : request to load the immediate
//   tx_command_valid      : TX command request for the current stage
//   tx_command_started    : TX side accepted the command
//   tx_data_next          : TX side can take the next serial bit
//   rx_started            : RX transfer has started
//   rx_data_valid         : RX serial bit valid this cycle
//   ext_wait              : PC/prefetch busy, stall everything
//   alu_en                : ALU serial cycle enable
//   counter               : serial cycle index inside the current pass
//   stage                 : current stage index
//   pass                  : current pass index of the current stage
//   command_active        : TX command running for the current pass
// -----------------------------------------------------------------------------
module stage_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int CYCLES     = 8,
    parameter int RC_BITS    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          inst_valid,
    output logic                          inst_done,
    input  logic [NUM_STAGES-1:0]         stage_mask,
    input  logic [NUM_STAGES-1:0]         cmd_mask,
    input  logic [NUM_STAGES-1:0]         rx_mask,
    input  logic [$clog2(NUM_STAGES)-1:0] repeat_stage,
    input  logic [RC_BITS-1:0]            repeat_count,
    input  logic                          skip,
    input  logic                          need_imm16,
    input  logic                          imm16_loaded,
    output logic                          load_imm16,
    output logic                          tx_command_valid,
    input  logic                          tx_command_started,
    input  logic                          tx_data_next,
    input  logic                          rx_started,
    input  logic                          rx_data_valid,
    input  logic                          ext_wait,
    output logic                          alu_en,
    output logic [$clog2(CYCLES)-1:0]     counter,
    output logic [$clog2(NUM_STAGES)-1:0] stage,
    output logic [RC_BITS-1:0]            pass,
    output logic                          command_active
);

    localparam int STAGE_W = $clog2(NUM_STAGES);
    localparam int CNT_W   = $clog2(CYCLES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IMM_WAIT = 2'd1,
        RUN      = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [STAGE_W-1:0]   stage_q, stage_d;
    logic [RC_BITS-1:0]   pass_q, pass_d;
    logic [CNT_W-1:0]     counter_q, counter_d;
    logic                 cmd_active_q, cmd_active_d;
    logic                 imm_avail_q, imm_avail_d;

    logic [NUM_STAGES-1:0] eff_mask;
    logic [STAGE_W-1:0]    first_stage;
    logic [STAGE_W-1:0]    next_stage;
    logic                  next_found;
    logic [RC_BITS:0]      pass_inc;
    logic                  cur_cmd;
    logic                  cur_rx;
    logic                  done_c;
    logic                  load_c;
    logic                  txv_c;
    logic                  alu_c;

    assign cur_cmd  = cmd_mask[stage_q];
    assign cur_rx   = rx_mask[stage_q];
    assign pass_inc = {1'b0, pass_q} + {{RC_BITS{1'b0}}, 1'b1};

    // A repeat stage asked to run zero passes is treated as if its mask bit
    // were clear, so it neither starts nor extends the instruction.
    always_comb begin
        eff_mask = stage_mask;
        if (repeat_count == '0) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (STAGE_W'(i) == repeat_stage) begin
                    eff_mask[i] = 1'b0;
                end
            end
        end
    end

    // Lowest effective stage (start point) and the lowest effective stage
    // above the current one (where a finished stage jumps to). Scanning from
    // the top down lets the last hit be the lowest index.
    always_comb begin
        first_stage = '0;
        next_stage  = '0;
        next_found  = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (eff_mask[i]) begin
                first_stage = STAGE_W'(i);
                if (STAGE_W'(i) > stage_q) begin
                    next_stage = STAGE_W'(i);
                    next_found = 1'b1;
                end
            end
        end
    end

    // Next-state and output decode. Pass end is the ALU cycle with the counter
    // at its top value; the command-active clear on pass end deliberately
    // overrides a simultaneous command start.
    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        pass_d       = pass_q;
        counter_d    = counter_q;
        cmd_active_d = cmd_active_q;
        imm_avail_d  = imm_avail_q;
        done_c       = 1'b0;
        load_c       = 1'b0;
        txv_c        = 1'b0;
        alu_c        = 1'b0;

        case (state_q)
            IDLE: begin
                if (inst_valid) begin
                    if (need_imm16 && !imm_avail_q) begin
                        load_c  = 1'b1;
                        state_d = IMM_WAIT;
                    end else if (skip || (eff_mask == '0)) begin
                        done_c      = 1'b1;
                        imm_avail_d = 1'b0;
                    end else begin
                        state_d      = RUN;
                        stage_d      = first_stage;
                        pass_d       = '0;
                        counter_d    = '0;
                        cmd_active_d = 1'b0;
                    end
                end
            end

            IMM_WAIT: begin
                load_c = 1'b1;
                if (imm16_loaded) begin
                    imm_avail_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            RUN: begin
                txv_c = cur_cmd && !cmd_active_q && !ext_wait &&
                        !(cur_rx && !rx_started);
                alu_c = !ext_wait && !(cur_rx && !rx_data_valid) &&
                        !(cur_cmd && !(cmd_active_q && tx_data_next));

                if (tx_command_started) begin
                    cmd_active_d = 1'b1;
                end

                if (alu_c) begin
                    counter_d = counter_q + CNT_W'(1);
                    if (&counter_q) begin
                        cmd_active_d = 1'b0;
                        if ((stage_q == repeat_stage) &&
                            (pass_inc < {1'b0, repeat_count})) begin
                            pass_d = pass_inc[RC_BITS-1:0];
                        end else begin
                            pass_d = '0;
                            if (next_found) begin
                                stage_d = next_stage;
                            end else begin
                                done_c      = 1'b1;
                                imm_avail_d = 1'b0;
                                state_d     = IDLE;
                            end
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            stage_q      <= '0;
            pass_q       <= '0;
            counter_q    <= '0;
            cmd_active_q <= 1'b0;
            imm_avail_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            pass_q       <= pass_d;
            counter_q    <= counter_d;
            cmd_active_q <= cmd_active_d;
            imm_avail_q  <= imm_avail_d;
        end
    end

    // Combinational outputs are masked by reset so an instruction held on the
    // inputs during reset cannot produce a load request or completion pulse.
    assign inst_done        = done_c & rst_n;
    assign load_imm16       = load_c & rst_n;
    assign tx_command_valid = txv_c & rst_n;
    assign alu_en           = alu_c & rst_n;
    assign counter          = counter_q;
    assign stage            = stage_q;
    assign pass             = pass_q;
    assign command_active   = cmd_active_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// Directed testbench for stage_sequencer with default parameters
// (4 stages, 8 serial cycles, 4-bit repeat count).
// -----------------------------------------------------------------------------
module tb_stage_sequencer;

    logic       clk;
    logic       rst_n;
    logic       inst_valid;
    logic       inst_done;
    logic [3:0] stage_mask;
    logic [3:0] cmd_mask;
    logic [3:0] rx_mask;
    logic [1:0] repeat_stage;
    logic [3:0] repeat_count;
    logic       skip;
    logic       need_imm16;
    logic       imm16_loaded;
    logic       load_imm16;
    logic       tx_command_valid;
    logic       tx_command_started;
    logic       tx_data_next;
    logic       rx_started;
    logic       rx_data_valid;
    logic       ext_wait;
    logic       alu_en;
    logic [2:0] counter;
    logic [1:0] stage;
    logic [3:0] pass;
    logic       command_active;

    int nChecks = 0;
    int nFails  = 0;
    int aluTotal;
    int doneAt;
    int loadCount;
    int maxPass;
    int aluPerStage [4];

    stage_sequencer #(
        .NUM_STAGES(4),
        .CYCLES    (8),
        .RC_BITS   (4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .inst_valid        (inst_valid),
        .inst_done         (inst_done),
        .stage_mask        (stage_mask),
        .cmd_mask          (cmd_mask),
        .rx_mask           (rx_mask),
        .repeat_stage      (repeat_stage),
        .repeat_count      (repeat_count),
        .skip              (skip),
        .need_imm16        (need_imm16),
        .imm16_loaded      (imm16_loaded),
        .load_imm16        (load_imm16),
        .tx_command_valid  (tx_command_valid),
        .tx_command_started(tx_command_started),
        .tx_data_next      (tx_data_next),
        .rx_started        (rx_started),
        .rx_data_valid     (rx_data_valid),
        .ext_wait          (ext_wait),
        .alu_en            (alu_en),
        .counter           (counter),
        .stage             (stage),
        .pass              (pass),
        .command_active    (command_active)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a directed step ever waits forever.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // One immediate assertion per comparison; failures are counted and reported.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Present a new instruction.
    task automatic applyStimulus(input logic [3:0] sm, input logic [3:0] cm,
                                 input logic [3:0] rm, input logic [1:0] rs,
                                 input logic [3:0] rc, input logic skp,
                                 input logic need);
        stage_mask   = sm;
        cmd_mask     = cm;
        rx_mask      = rm;
        repeat_stage = rs;
        repeat_count = rc;
        skip         = skp;
        need_imm16   = need;
        inst_valid   = 1'b1;
    endtask

    task automatic clearInputs();
        inst_valid         = 1'b0;
        stage_mask         = '0;
        cmd_mask           = '0;
        rx_mask            = '0;
        repeat_stage       = '0;
        repeat_count       = '0;
        skip               = 1'b0;
        need_imm16         = 1'b0;
        imm16_loaded       = 1'b0;
        tx_command_started = 1'b0;
        tx_data_next       = 1'b0;
        rx_started         = 1'b0;
        rx_data_valid      = 1'b0;
        ext_wait           = 1'b0;
    endtask

    task automatic checkAllZero(input string pfx);
        checkOutput({pfx, "_inst_done"}, inst_done, 0);
        checkOutput({pfx, "_load_imm16"}, load_imm16, 0);
        checkOutput({pfx, "_tx_cmd_valid"}, tx_command_valid, 0);
        checkOutput({pfx, "_alu_en"}, alu_en, 0);
        checkOutput({pfx, "_counter"}, counter, 0);
        checkOutput({pfx, "_stage"}, stage, 0);
        checkOutput({pfx, "_pass"}, pass, 0);
        checkOutput({pfx, "_cmd_active"}, command_active, 0);
    endtask

    // Run the presented instruction until inst_done (bounded), recording ALU
    // activity per stage, load_imm16 cycles and the cycle of completion.
    // Cycle 0 is the first IDLE cycle that sees inst_valid.
    task automatic runInstruction(input int maxCycles, input int immAt,
                                  input int skipFlipAt);
        aluTotal  = 0;
        doneAt    = -1;
        loadCount = 0;
        maxPass   = 0;
        for (int i = 0; i < 4; i++) aluPerStage[i] = 0;
        for (int cyc = 0; cyc < maxCycles; cyc++) begin
            imm16_loaded = (cyc == immAt);
            if (cyc == skipFlipAt) skip = ~skip;
            #1;
            if (load_imm16) loadCount++;
            if (alu_en) begin
                aluTotal++;
                aluPerStage[stage]++;
                if (int'(pass) > maxPass) maxPass = int'(pass);
            end
            if (inst_done) begin
                doneAt = cyc;
                break;
            end
            nextCycle();
        end
        nextCycle();
        inst_valid   = 1'b0;
        imm16_loaded = 1'b0;
    endtask

    // Directed sequence.
    initial begin
        clearInputs();
        rst_n = 1'b0;

        // Reset with an instruction needing an immediate held on the inputs.
        applyStimulus(4'b1111, 4'b0000, 4'b0000, 2'd0, 4'd1, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        clearInputs();
        rst_n = 1'b1;
        nextCycle();
        checkOutput("idle_after_reset_alu", alu_en, 0);

        // Two stages, one pass each.
        $display("[TB] two stages 0 and 2");
        applyStimulus(4'b0101, 4'b0000, 4'b0000, 2'd0, 4'd1, 1'b0, 1'b0);
        runInstruction(40, -1, -1);
        checkOutput("s02_done_cycle", doneAt, 16);
        checkOutput("s02_alu_total", aluTotal, 16);
        checkOutput("s02_alu_stage0", aluPerStage[0], 8);
        checkOutput("s02_alu_stage1", aluPerStage[1], 0);
        checkOutput("s02_alu_stage2", aluPerStage[2], 8);

        // Repeat stage 3 for three passes; skip toggles mid-run without effect.
        $display("[TB] repeat stage 3 three passes");
        applyStimulus(4'b1001, 4'b0000, 4'b0000, 2'd3, 4'd3, 1'b0, 1'b0);
        runInstruction(60, -1, 3);
        skip = 1'b0;
        checkOutput("rep_done_cycle", doneAt, 32);
        checkOutput("rep_alu_total", aluTotal, 32);
        checkOutput("rep_alu_stage0", aluPerStage[0], 8);
        checkOutput("rep_alu_stage3", aluPerStage[3], 24);
        checkOutput("rep_max_pass", maxPass, 2);

        // Only stage is the repeat stage with zero passes: done immediately.
        $display("[TB] zero repeat count");
        applyStimulus(4'b1000, 4'b0000, 4'b0000, 2'd3, 4'd0, 1'b0, 1'b0);
        runInstruction(20, -1, -1);
        checkOutput("rc0_done_cycle", doneAt, 0);
        checkOutput("rc0_alu_total", aluTotal, 0);

        // Immediate load taking five request cycles, then one stage.
        $display("[TB] imm16 load then run");
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 2'd0, 4'd1, 1'b0, 1'b1);
        runInstruction(40, 4, -1);
        checkOutput("imm_load_cycles", loadCount, 5);
        checkOutput("imm_done_cycle", doneAt, 13);
        checkOutput("imm_alu_total", aluTotal, 8);

        // Skipped instruction that still needs its immediate (must reload).
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 2'd0, 4'd1, 1'b1, 1'b1);
        runInstruction(20, 2, -1);
        checkOutput("immskip_load_cycles", loadCount, 3);
        checkOutput("immskip_done_cycle", doneAt, 3);
        checkOutput("immskip_alu_total", aluTotal, 0);
        clearInputs();

        // Command stages with RX gating and a command start on pass end.
        $display("[TB] command and rx handshakes");
        applyStimulus(4'b0011, 4'b0011, 4'b0001, 2'd0, 4'd1, 1'b0, 1'b0);
        #1;
        checkOutput("cmd_c0_alu", alu_en, 0);
        nextCycle();
        #1;
        checkOutput("cmd_c1_txv_wait_rx", tx_command_valid, 0);
        checkOutput("cmd_c1_alu", alu_en, 0);
        checkOutput("cmd_c1_stage", stage, 0);
        nextCycle();
        rx_started = 1'b1;
        #1;
        checkOutput("cmd_c2_txv", tx_command_valid, 1);
        checkOutput("cmd_c2_alu", alu_en, 0);
        tx_command_started = 1'b1;
        nextCycle();
        tx_command_started = 1'b0;
        tx_data_next       = 1'b1;
        #1;
        checkOutput("cmd_c3_active", command_active, 1);
        checkOutput("cmd_c3_txv", tx_command_valid, 0);
        checkOutput("cmd_c3_alu_wait_rxdata", alu_en, 0);
        nextCycle();
        rx_data_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) tx_command_started = 1'b1;
            #1;
            checkOutput("cmd_s0_alu", alu_en, 1);
            checkOutput("cmd_s0_counter", counter, k);
            if (k == 7) checkOutput("cmd_s0_no_done", inst_done, 0);
            nextCycle();
        end
        tx_command_started = 1'b0;
        rx_data_valid      = 1'b0;
        tx_data_next       = 1'b0;
        ext_wait           = 1'b1;
        #1;
        checkOutput("cmd_s1_stage", stage, 1);
        checkOutput("cmd_s1_active_cleared", command_active, 0);
        checkOutput("cmd_s1_txv_extwait", tx_command_valid, 0);
        checkOutput("cmd_s1_alu_extwait", alu_en, 0);
        nextCycle();
        ext_wait = 1'b0;
        #1;
        checkOutput("cmd_s1_txv", tx_command_valid, 1);
        checkOutput("cmd_s1_alu_no_cmd", alu_en, 0);
        tx_command_started = 1'b1;
        nextCycle();
        tx_command_started = 1'b0;
        tx_data_next       = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            checkOutput("cmd_s1_alu", alu_en, 1);
            checkOutput("cmd_s1_done", inst_done, (k == 7) ? 1 : 0);
            nextCycle();
        end
        inst_valid         = 1'b0;
        tx_data_next       = 1'b0;
        tx_command_started = 1'b1;
        nextCycle();
        tx_command_started = 1'b0;
        #1;
        checkOutput("idle_txstart_ignored", command_active, 0);
        clearInputs();
        nextCycle();

        // Reset in the middle of stage 1 at counter 5, then a clean restart.
        $display("[TB] reset abort mid-run");
        applyStimulus(4'b0011, 4'b0000, 4'b0000, 2'd0, 4'd1, 1'b0, 1'b0);
        for (int cyc = 0; cyc < 14; cyc++) nextCycle();
        #1;
        checkOutput("abort_pre_stage", stage, 1);
        checkOutput("abort_pre_counter", counter, 5);
        rst_n      = 1'b0;
        need_imm16 = 1'b1;
        #1;
        checkAllZero("abort");
        for (int cyc = 0; cyc < 3; cyc++) begin
            nextCycle();
            #1;
            checkOutput("abort_hold_done", inst_done, 0);
            checkOutput("abort_hold_load", load_imm16, 0);
        end
        clearInputs();
        rst_n = 1'b1;
        nextCycle();
        applyStimulus(4'b0011, 4'b0000, 4'b0000, 2'd0, 4'd1, 1'b0, 1'b0);
        runInstruction(40, -1, -1);
        checkOutput("restart_done_cycle", doneAt, 16);
        checkOutput("restart_alu_total", aluTotal, 16);
        checkOutput("restart_alu_stage1", aluPerStage[1], 8);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4: number of stage slots per instruction (2..8).
REQ-002 SHALL have parameter CYCLES, default 8: ALU serial cycles per stage pass (power of two, 2..16).
REQ-003 SHALL have parameter RC_BITS, default 4: width of the repeat count.
REQ-004 SHALL have ports clk input 1 (single clock) and rst_n input 1 (asynchronous, active-low reset).
REQ-005 SHALL have port inst_valid input 1: instruction present; inputs below remain stable until inst_done.
REQ-006 SHALL have port inst_done output 1: single-cycle completion pulse.
REQ-007 SHALL have port stage_mask input NUM_STAGES: stages to execute.
REQ-008 SHALL have port cmd_mask input NUM_STAGES: stages that issue a TX command.
REQ-009 SHALL have port rx_mask input NUM_STAGES: stages that consume RX data.
REQ-010 SHALL have ports repeat_stage input clog2(NUM_STAGES) and repeat_count input RC_BITS: the stage index that executes repeat_count passes.
REQ-011 SHALL have port skip input 1: condition failed or no-op.
REQ-012 SHALL have ports need_imm16 input 1, imm16_loaded input 1 and load_imm16 output 1.
REQ-013 SHALL have ports tx_command_valid output 1, tx_command_started input 1 and tx_data_next input 1.
REQ-014 SHALL have ports rx_started input 1 and rx_data_valid input 1.
REQ-015 SHALL have port ext_wait input 1: PC/prefetch not idle.
REQ-016 SHALL have ports alu_en output 1, counter output clog2(CYCLES), stage output clog2(NUM_STAGES), pass output RC_BITS and command_active output 1.

Function
REQ-017 SHALL implement states IDLE, IMM_WAIT, RUN.
REQ-018 In IDLE with inst_valid=1, the block SHALL assert load_imm16 combinationally and enter IMM_WAIT when need_imm16=1 and imm16 is not yet available.
REQ-019 Otherwise in IDLE with inst_valid=1, the block SHALL pulse inst_done that cycle if skip=1 or stage_mask has no effective stage, and SHALL stay in IDLE.
REQ-020 Otherwise in IDLE with inst_valid=1, the block SHALL enter RUN with stage = lowest effective stage, pass=0 and counter=0.
REQ-021 An effective stage SHALL be a stage whose mask bit is 1, excluding repeat_stage when repeat_count=0.
REQ-022 In IMM_WAIT, load_imm16 SHALL stay 1 until imm16_loaded=1, which sets imm16_available; the next cycle SHALL re-evaluate as in IDLE.
REQ-023 imm16_available SHALL clear on inst_done.
REQ-024 In RUN with cmd_mask[stage]=1 and command_active=0, tx_command_valid SHALL be 1 unless ext_wait=1 or (rx_mask[stage]=1 and rx_started=0).
REQ-025 tx_command_started=1 SHALL set command_active on the next edge.
REQ-026 alu_en SHALL be 1 in RUN unless ext_wait=1, or (rx_mask[stage]=1 and rx_data_valid=0), or (cmd_mask[stage]=1 and !(command_active and tx_data_next)).
REQ-027 counter SHALL increment modulo CYCLES on each alu_en cycle.
REQ-028 A pass SHALL end on the alu_en cycle with counter=CYCLES-1.
REQ-029 At pass end, command_active SHALL clear.
REQ-030 At pass end, if stage=repeat_stage and pass<repeat_count-1, pass SHALL increment and stage SHALL hold.
REQ-031 At pass end when REQ-030 does not apply, pass SHALL clear and stage SHALL jump to the next higher effective stage.
REQ-032 At pass end with no higher effective stage, inst_done SHALL pulse that same cycle and the state SHALL return to IDLE.
REQ-033 A new instruction SHALL be accepted no earlier than the cycle after inst_done.
REQ-034 tx_command_started and tx_data_next SHALL be ignored outside RUN.
REQ-035 Simultaneous tx_command_started and pass end SHALL leave command_active=0 (the clear wins).
REQ-036 skip SHALL be sampled only in IDLE/IMM_WAIT; a change of skip during RUN SHALL have no effect.

Reset
REQ-037 rst_n=0 SHALL asynchronously force state=IDLE, stage=0, pass=0, counter=0, command_active=0 and imm16_available=0.
REQ-038 During reset, all outputs SHALL be 0, including an abort mid-RUN, with no inst_done pulse.
REQ-039 Release of rst_n SHALL take effect on the first clk edge after deassertion.

Verification
REQ-040 Bench SHALL cover: stage_mask=0101, no cmd/rx, repeat_count=1 -> stages 0,2 each 8 alu_en cycles, inst_done on cycle 16 of RUN.
REQ-041 Bench SHALL cover: repeat_stage=3, repeat_count=3, mask=1001 -> stage 3 executes passes 0..2, inst_done after 32 alu_en cycles.
REQ-042 Bench SHALL cover: repeat_count=0, mask=1000, repeat_stage=3 -> inst_done pulses in the IDLE cycle, alu_en never 1.
REQ-043 Bench SHALL cover: need_imm16=1, imm16_loaded after 5 cycles -> load_imm16 high 5 cycles, then RUN; a skip=1 instruction with need_imm16=1 gives inst_done only after the load completes.
REQ-044 Bench SHALL cover: cmd stage with rx_mask=1 -> tx_command_valid held 0 until rx_started, alu_en 0 until rx_data_valid; tx_command_started coinciding with pass end gives command_active=0.
REQ-045 Bench SHALL cover: rst_n pulsed low at counter=5 of stage 1 -> all outputs 0 immediately, no inst_done, clean restart on the next inst_valid.
